// File: rtl/uart_pkg.sv
// Shared UART definitions: receive/transmit state encoding and baud timing helper.
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Clock cycles per line bit.
  function automatic int unsigned bit_cycles(input int unsigned clkf, input int unsigned baud);
    return clkf / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1-style framing, mid-bit sampling, valid/ready output with
// framing-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD = 9600,
  parameter int unsigned CLKF = 100000000,
  parameter int unsigned DLEN = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_rxs,
  output logic            o_rvalid,
  input  logic            i_rready,
  output logic [DLEN-1:0] o_rdata,
  output logic            o_ferr,
  output logic            o_ovr
);

  localparam int unsigned BIT_CYCLES  = bit_cycles(CLKF, BAUD);
  localparam int unsigned HALF_CYCLES = BIT_CYCLES / 2;
  localparam int unsigned CNT_W       = $clog2(BIT_CYCLES);
  localparam int unsigned BIT_W       = $clog2(DLEN + 1);

  logic rxs;

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [DLEN-1:0]  shift_q, shift_d;
  logic             armed_q, armed_d;
  logic             rvalid_q, rvalid_d;
  logic [DLEN-1:0]  rdata_q, rdata_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             cnt_last_c;
  logic             cnt_half_c;
  logic             good_c;
  logic             bad_c;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rstn),
    .d_i  (i_rxs),
    .q_o  (rxs)
  );

  assign cnt_last_c = (cnt_q == CNT_W'(BIT_CYCLES - 1));
  assign cnt_half_c = (cnt_q == CNT_W'(HALF_CYCLES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= RX_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      armed_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      armed_q  <= armed_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    armed_d  = 1'b0;
    good_c   = 1'b0;
    bad_c    = 1'b0;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    ferr_d   = 1'b0;
    ovr_d    = 1'b0;

    case (state_q)
      // armed_q records that the line was high on the previous idle cycle,
      // so a held-low line (break) cannot re-trigger a frame.
      RX_IDLE: begin
        cnt_d   = '0;
        bit_d   = '0;
        armed_d = rxs;
        if (!rxs && armed_q) begin
          state_d = RX_START;
        end
      end
      RX_START: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_half_c) begin
          cnt_d   = '0;
          state_d = rxs ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_last_c) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[DLEN-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_W'(DLEN - 1)) begin
            bit_d   = '0;
            state_d = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_last_c) begin
          cnt_d   = '0;
          good_c  = rxs;
          bad_c   = !rxs;
          state_d = RX_IDLE;
        end
      end
      default: begin
        state_d = RX_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
`ifndef SYNTHESIS
        $error("uart_rx: illegal state %0d", state_q);
`endif
      end
    endcase

    // Output holding register; a handshake in the same cycle frees it for the new word.
    if (rvalid_q && i_rready) begin
      rvalid_d = 1'b0;
    end
    ferr_d = bad_c;
    if (good_c) begin
      if (rvalid_q && !i_rready) begin
        ovr_d = 1'b1;
      end else begin
        rvalid_d = 1'b1;
        rdata_d  = shift_q;
      end
    end
  end

  assign o_rvalid = rvalid_q;
  assign o_rdata  = rdata_q;
  assign o_ferr   = ferr_q;
  assign o_ovr    = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames in, monitor checks words and pulses.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned CLKF = 3200000;
  localparam int unsigned BAUD = 100000;
  localparam int unsigned DLEN = 8;
  localparam int unsigned BC   = 32;

  logic            clk;
  logic            rstn;
  logic            i_rxs;
  logic            o_rvalid;
  logic            i_rready;
  logic [DLEN-1:0] o_rdata;
  logic            o_ferr;
  logic            o_ovr;

  int checks = 0;
  int errors = 0;

  logic [DLEN-1:0] data_exp[$];
  int ferr_pend = 0;
  int ovr_pend  = 0;

  uart_rx #(
    .BAUD(BAUD),
    .CLKF(CLKF),
    .DLEN(DLEN)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .i_rxs   (i_rxs),
    .o_rvalid(o_rvalid),
    .i_rready(i_rready),
    .o_rdata (o_rdata),
    .o_ferr  (o_ferr),
    .o_ovr   (o_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    i_rxs = b;
    tick(BC);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((data_exp.size() != 0 || ferr_pend != 0 || ovr_pend != 0) && n < 8 * BC) begin
      tick(1);
      n++;
    end
    checks++;
    if (data_exp.size() != 0 || ferr_pend != 0 || ovr_pend != 0) begin
      errors++;
      $display("FAIL %s: outstanding words=%0d ferr=%0d ovr=%0d expected all 0",
               name, data_exp.size(), ferr_pend, ovr_pend);
    end
  endtask

  // Monitor: pops expectations on handshakes and pulses, checks hold stability.
  logic            prev_ferr = 1'b0;
  logic            prev_ovr  = 1'b0;
  logic            hold_prev = 1'b0;
  logic [DLEN-1:0] held      = '0;

  always @(negedge clk) begin
    if (!rstn) begin
      prev_ferr = 1'b0;
      prev_ovr  = 1'b0;
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        checks++;
        if (!o_rvalid || o_rdata !== held) begin
          errors++;
          $display("FAIL hold: rvalid=%0b rdata=0x%0h expected rvalid=1 rdata=0x%0h",
                   o_rvalid, o_rdata, held);
        end
      end
      if (o_rvalid && i_rready) begin
        checks++;
        if (data_exp.size() == 0) begin
          errors++;
          $display("FAIL word: got unexpected 0x%0h expected none", o_rdata);
        end else begin
          logic [DLEN-1:0] e;
          e = data_exp.pop_front();
          if (o_rdata !== e) begin
            errors++;
            $display("FAIL word: got 0x%0h expected 0x%0h", o_rdata, e);
          end
        end
      end
      if (o_ferr) begin
        checks++;
        if (ferr_pend == 0 || prev_ferr) begin
          errors++;
          $display("FAIL ferr: got pulse (pending=%0d repeat=%0b) expected none", ferr_pend, prev_ferr);
        end else begin
          ferr_pend--;
        end
      end
      if (o_ovr) begin
        checks++;
        if (ovr_pend == 0 || prev_ovr) begin
          errors++;
          $display("FAIL ovr: got pulse (pending=%0d repeat=%0b) expected none", ovr_pend, prev_ovr);
        end else begin
          ovr_pend--;
        end
      end
      prev_ferr = o_ferr;
      prev_ovr  = o_ovr;
      hold_prev = o_rvalid && !i_rready;
      held      = o_rdata;
    end
  end

  initial begin
    rstn     = 1'b0;
    i_rxs    = 1'b1;
    i_rready = 1'b0;
    tick(5);
    check("rst_rvalid", 32'(o_rvalid), 32'd0);
    check("rst_rdata", 32'(o_rdata), 32'd0);
    check("rst_ferr", 32'(o_ferr), 32'd0);
    check("rst_ovr", 32'(o_ovr), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(RX_IDLE));
    rstn = 1'b1;
    tick(2 * BC);

    // Good frame with consumer ready.
    i_rready = 1'b1;
    data_exp.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    send_bit(1'b1);
    wait_drain("t1_drain");
    check("t1_rvalid_low", 32'(o_rvalid), 32'd0);

    // Short low glitch rejected.
    i_rxs = 1'b0;
    tick(5);
    i_rxs = 1'b1;
    tick(3 * BC);
    check("t2_state", 32'(dut.state_q), 32'(RX_IDLE));
    check("t2_rvalid", 32'(o_rvalid), 32'd0);

    // Framing error.
    ferr_pend++;
    send_frame(8'h3C, 1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    wait_drain("t3_drain");
    check("t3_rvalid", 32'(o_rvalid), 32'd0);

    // Overrun while consumer stalled.
    i_rready = 1'b0;
    data_exp.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_bit(1'b1);
    check("t4_rvalid_held", 32'(o_rvalid), 32'd1);
    check("t4_rdata_held", 32'(o_rdata), 32'h11);
    ovr_pend++;
    send_frame(8'h22, 1'b1);
    send_bit(1'b1);
    check("t4_ovr_seen", 32'(ovr_pend), 32'd0);
    check("t4_rdata_kept", 32'(o_rdata), 32'h11);
    i_rready = 1'b1;
    tick(1);
    check("t4_rvalid_drop", 32'(o_rvalid), 32'd0);
    wait_drain("t4_drain");

    // Back-to-back frames.
    data_exp.push_back(8'h00);
    data_exp.push_back(8'hFF);
    data_exp.push_back(8'h5A);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h5A, 1'b1);
    send_bit(1'b1);
    wait_drain("t5_drain");

    // Reset during data bit 4 of 0x81, then a clean frame.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h81 >> i));
    i_rxs = 1'b0;
    tick(BC / 2);
    rstn = 1'b0;
    tick(5);
    check("t6_rst_rvalid", 32'(o_rvalid), 32'd0);
    check("t6_rst_state", 32'(dut.state_q), 32'(RX_IDLE));
    i_rxs = 1'b1;
    rstn  = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);
    data_exp.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    send_bit(1'b1);
    wait_drain("t6_drain");
    check("t6_rvalid_low", 32'(o_rvalid), 32'd0);

    tick(2 * BC);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
